// File: rtl/spad_wr_buf.sv
// Write-side controller for the 16 x 32 M scratchpad array.
// Owns the shared address port. A one-entry write buffer lets reads take the port first.
// Reads of a buffered register return the buffered bytes merged over the array data.
module spad_wr_buf (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        wr_req_h,
    input  logic [3:0]  wr_addr_h,
    input  logic [1:0]  wr_len_h,
    input  logic [31:0] wr_data_h,
    input  logic        rd_en_h,
    input  logic [3:0]  rd_addr_h,
    input  logic [31:0] mbus_l,
    output logic [3:0]  mspa_h,
    output logic [3:0]  spw_l,
    output logic [31:0] wbus_h,
    output logic        mcs_tmp_l,
    output logic [31:0] rd_data_h,
    output logic        stall_h
);

    logic        buf_v;
    logic [3:0]  buf_addr;
    logic [31:0] buf_data;
    logic [3:0]  buf_mask;

    // Last driven port values, so an idle port keeps address and data stable.
    logic [3:0]  mspa_q;
    logic [31:0] wbus_q;

    logic [3:0]  wmask;
    logic [31:0] merged_data;
    logic        req_ok;
    logic        retire;
    logic        hit_wr;
    logic        hit_rd;
    logic        coalesce;
    logic        load;

    // Length decode; the no-op length yields an empty mask.
    always_comb begin
        wmask = 4'b0000;
        case (wr_len_h)
            2'b00:   wmask = 4'b0001;
            2'b01:   wmask = 4'b0011;
            2'b10:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    assign req_ok   = wr_req_h & (wr_len_h != 2'b11);
    assign retire   = buf_v & ~rd_en_h;
    assign hit_wr   = (wr_addr_h == buf_addr);
    assign hit_rd   = buf_v & (rd_addr_h == buf_addr);
    assign coalesce = req_ok & buf_v & rd_en_h & hit_wr;
    // Held buffer for a different register cannot absorb the write.
    assign stall_h  = req_ok & buf_v & rd_en_h & ~hit_wr;
    // A retiring entry frees the buffer in the same cycle it drains.
    assign load     = req_ok & (~buf_v | retire);

    // Byte-lane merge of a new write into the held entry.
    always_comb begin
        merged_data = buf_data;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
                merged_data[8*i +: 8] = wr_data_h[8*i +: 8];
            end
        end
    end

    // Write buffer: load, coalesce or drain.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            buf_v    <= 1'b0;
            buf_addr <= 4'd0;
            buf_data <= 32'd0;
            buf_mask <= 4'd0;
        end else if (load) begin
            buf_v    <= 1'b1;
            buf_addr <= wr_addr_h;
            buf_data <= wr_data_h;
            buf_mask <= wmask;
        end else if (coalesce) begin
            buf_data <= merged_data;
            buf_mask <= buf_mask | wmask;
        end else if (retire) begin
            buf_v    <= 1'b0;
        end
    end

    // Port arbitration: read first, then buffered write, otherwise hold the port.
    always_comb begin
        mspa_h    = mspa_q;
        wbus_h    = wbus_q;
        spw_l     = 4'b1111;
        mcs_tmp_l = 1'b1;
        if (!rst_l) begin
            mspa_h = 4'd0;
            wbus_h = 32'd0;
        end else if (rd_en_h) begin
            mspa_h    = rd_addr_h;
            mcs_tmp_l = 1'b0;
        end else if (buf_v) begin
            mspa_h = buf_addr;
            spw_l  = ~buf_mask;
            wbus_h = buf_data;
        end
    end

    // Remember the last port address and data for idle cycles.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            mspa_q <= 4'd0;
            wbus_q <= 32'd0;
        end else begin
            mspa_q <= mspa_h;
            wbus_q <= wbus_h;
        end
    end

    // Zero-latency read with buffered lanes overriding array data.
    always_comb begin
        rd_data_h = 32'd0;
        if (rst_l && rd_en_h) begin
            for (int i = 0; i < 4; i++) begin
                if (hit_rd && buf_mask[i]) begin
                    rd_data_h[8*i +: 8] = buf_data[8*i +: 8];
                end else begin
                    rd_data_h[8*i +: 8] = ~mbus_l[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_spad_wr_buf.sv
// Bench for spad_wr_buf: array model plus a coherency reference (latest accepted value per register).
module tb_spad_wr_buf;

    logic        clk;
    logic        rst_l;
    logic        wr_req_h;
    logic [3:0]  wr_addr_h;
    logic [1:0]  wr_len_h;
    logic [31:0] wr_data_h;
    logic        rd_en_h;
    logic [3:0]  rd_addr_h;
    logic [31:0] mbus_l;
    logic [3:0]  mspa_h;
    logic [3:0]  spw_l;
    logic [31:0] wbus_h;
    logic        mcs_tmp_l;
    logic [31:0] rd_data_h;
    logic        stall_h;

    spad_wr_buf dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .wr_req_h  (wr_req_h),
        .wr_addr_h (wr_addr_h),
        .wr_len_h  (wr_len_h),
        .wr_data_h (wr_data_h),
        .rd_en_h   (rd_en_h),
        .rd_addr_h (rd_addr_h),
        .mbus_l    (mbus_l),
        .mspa_h    (mspa_h),
        .spw_l     (spw_l),
        .wbus_h    (wbus_h),
        .mcs_tmp_l (mcs_tmp_l),
        .rd_data_h (rd_data_h),
        .stall_h   (stall_h)
    );

    int tests = 0;
    int fails = 0;

    // Physical array contents and the value software should observe for each register.
    logic [31:0] mem    [16];
    logic [31:0] shadow [16];
    // Pending (not yet in the array) write, tracked as register plus set of bytes.
    logic        pend_v;
    logic [3:0]  pend_addr;
    logic [3:0]  pend_bytes;
    logic        last_stall;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mbus_l = mcs_tmp_l ? 32'hFFFF_FFFF : ~mem[mspa_h];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!spw_l[i]) mem[mspa_h][8*i +: 8] <= wbus_h[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] bytes_of(input logic [1:0] len);
        if (len == 2'd0) return 4'b0001;
        if (len == 2'd1) return 4'b0011;
        if (len == 2'd2) return 4'b1111;
        return 4'b0000;
    endfunction

    task automatic drive(input logic req, input logic [3:0] addr, input logic [1:0] len,
                         input logic [31:0] data, input logic rd, input logic [3:0] raddr);
        wr_req_h  = req;
        wr_addr_h = addr;
        wr_len_h  = len;
        wr_data_h = data;
        rd_en_h   = rd;
        rd_addr_h = raddr;
        #1;
    endtask

    // Check one cycle against the reference, then advance the model across the edge.
    task automatic cyc();
        logic        valid_req;
        logic        exp_stall;
        logic [3:0]  b;
        logic [31:0] nshadow;
        logic        n_v;
        logic [3:0]  n_addr;
        logic [3:0]  n_bytes;
        logic [31:0] lane_exp;
        logic [31:0] lane_obs;

        valid_req = wr_req_h && (wr_len_h != 2'b11);
        b         = bytes_of(wr_len_h);
        exp_stall = valid_req && pend_v && rd_en_h && (wr_addr_h != pend_addr);
        last_stall = exp_stall;

        chk("stall", {31'd0, stall_h}, {31'd0, exp_stall});
        chk("rd_data", rd_data_h, rd_en_h ? shadow[rd_addr_h] : 32'd0);
        chk("mcs", {31'd0, mcs_tmp_l}, {31'd0, !rd_en_h});
        chk("excl", {31'd0, (!mcs_tmp_l && spw_l != 4'hF)}, 32'd0);
        if (rd_en_h || !pend_v) begin
            chk("spw_idle", {28'd0, spw_l}, 32'h0000_000F);
        end else begin
            chk("spw_ret", {28'd0, spw_l}, {28'd0, ~pend_bytes});
            chk("mspa_ret", {28'd0, mspa_h}, {28'd0, pend_addr});
            lane_exp = 32'd0;
            lane_obs = 32'd0;
            for (int i = 0; i < 4; i++) begin
                if (pend_bytes[i]) begin
                    lane_exp[8*i +: 8] = shadow[pend_addr][8*i +: 8];
                    lane_obs[8*i +: 8] = wbus_h[8*i +: 8];
                end
            end
            chk("wbus_ret", lane_obs, lane_exp);
        end

        n_v     = pend_v && rd_en_h;
        n_addr  = pend_addr;
        n_bytes = pend_bytes;
        nshadow = shadow[wr_addr_h];
        if (valid_req && !exp_stall) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) nshadow[8*i +: 8] = wr_data_h[8*i +: 8];
            end
            if (pend_v && rd_en_h) begin
                n_bytes = pend_bytes | b;
            end else begin
                n_addr  = wr_addr_h;
                n_bytes = b;
            end
            n_v = 1'b1;
        end
        @(posedge clk);
        if (valid_req && !exp_stall) shadow[wr_addr_h] = nshadow;
        pend_v     = n_v;
        pend_addr  = n_addr;
        pend_bytes = n_bytes;
        @(negedge clk);
    endtask

    initial begin
        logic        r_req;
        logic [3:0]  r_addr;
        logic [1:0]  r_len;
        logic [31:0] r_data;

        for (int i = 0; i < 16; i++) begin
            mem[i]    = $urandom;
            shadow[i] = mem[i];
        end
        pend_v = 1'b0; pend_addr = 4'd0; pend_bytes = 4'd0; last_stall = 1'b0;

        // Reset with activity on the inputs: port must be quiet.
        rst_l = 1'b0;
        drive(1'b1, 4'd5, 2'd2, 32'h1234_5678, 1'b1, 4'd6);
        chk("rst_spw", {28'd0, spw_l}, 32'h0000_000F);
        chk("rst_mcs", {31'd0, mcs_tmp_l}, 32'd1);
        chk("rst_mspa", {28'd0, mspa_h}, 32'd0);
        chk("rst_wbus", wbus_h, 32'd0);
        chk("rst_stall", {31'd0, stall_h}, 32'd0);
        chk("rst_rd", rd_data_h, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        cyc();

        // 1: idle long write retires the next cycle.
        drive(1'b1, 4'd3, 2'd2, 32'hDEAD_BEEF, 1'b0, 4'd0);
        cyc();
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        chk("t1_spw", {28'd0, spw_l}, 32'h0000_0000);
        chk("t1_mspa", {28'd0, mspa_h}, 32'd3);
        chk("t1_wbus", wbus_h, 32'hDEAD_BEEF);
        cyc();
        chk("t1_spw_off", {28'd0, spw_l}, 32'h0000_000F);
        cyc();

        // 2: byte write under a read of the same register, forwarded from cycle 2.
        mem[7] = 32'h1122_3344;
        shadow[7] = 32'h1122_3344;
        drive(1'b1, 4'd7, 2'd0, 32'h0000_005A, 1'b1, 4'd7);
        chk("t2_c1", rd_data_h, 32'h1122_3344);
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b1, 4'd7);
            chk("t2_fwd", rd_data_h, 32'h1122_335A);
            chk("t2_spw", {28'd0, spw_l}, 32'h0000_000F);
            cyc();
        end
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        chk("t2_ret_spw", {28'd0, spw_l}, 32'h0000_000E);
        chk("t2_ret_mspa", {28'd0, mspa_h}, 32'd7);
        cyc();
        cyc();
        chk("t2_mem", mem[7], 32'h1122_335A);

        // 3: conflicting write stalls until the read drops, then load-on-retire.
        drive(1'b1, 4'd2, 2'd2, 32'hCAFE_0002, 1'b1, 4'd5);
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'd9, 2'd2, 32'hCAFE_0009, 1'b1, 4'd5);
            chk("t3_stall", {31'd0, stall_h}, 32'd1);
            cyc();
        end
        drive(1'b1, 4'd9, 2'd2, 32'hCAFE_0009, 1'b0, 4'd0);
        chk("t3_nostall", {31'd0, stall_h}, 32'd0);
        chk("t3_mspa2", {28'd0, mspa_h}, 32'd2);
        cyc();
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        chk("t3_mspa9", {28'd0, mspa_h}, 32'd9);
        chk("t3_wbus9", wbus_h, 32'hCAFE_0009);
        cyc();
        chk("t3_done", {28'd0, spw_l}, 32'h0000_000F);
        cyc();

        // 4: coalesce byte then word into one entry.
        drive(1'b1, 4'd4, 2'd0, 32'h0000_00AA, 1'b1, 4'd1);
        cyc();
        drive(1'b1, 4'd4, 2'd1, 32'h0000_BBCC, 1'b1, 4'd1);
        chk("t4_nostall", {31'd0, stall_h}, 32'd0);
        cyc();
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b1, 4'd4);
        chk("t4_rd_lo", {16'd0, rd_data_h[15:0]}, 32'h0000_BBCC);
        cyc();
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        chk("t4_spw", {28'd0, spw_l}, 32'h0000_000C);
        chk("t4_wbus", {16'd0, wbus_h[15:0]}, 32'h0000_BBCC);
        cyc();
        cyc();

        // 5: no-op length never stalls or writes; reset drops a pending write.
        drive(1'b1, 4'd6, 2'd3, 32'hFFFF_FFFF, 1'b1, 4'd6);
        chk("t5_noop_stall", {31'd0, stall_h}, 32'd0);
        cyc();
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        chk("t5_noop_spw", {28'd0, spw_l}, 32'h0000_000F);
        cyc();
        drive(1'b1, 4'd1, 2'd2, 32'h0BAD_F00D, 1'b1, 4'd0);
        cyc();
        drive(1'b1, 4'd8, 2'd3, 32'h0, 1'b1, 4'd0);
        chk("t5_noop_held", {31'd0, stall_h}, 32'd0);
        cyc();
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        chk("t5_pre_rst", {28'd0, spw_l}, 32'h0000_0000);
        rst_l = 1'b0;
        #1;
        chk("t5_rst_spw", {28'd0, spw_l}, 32'h0000_000F);
        pend_v = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = mem[i];
        @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        chk("t5_no_retire", {28'd0, spw_l}, 32'h0000_000F);
        cyc();

        // Randomized traffic on a few registers, requester holds while stalled.
        r_req = 1'b0; r_addr = 4'd0; r_len = 2'd0; r_data = 32'd0;
        last_stall = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                r_req  = ($urandom_range(0, 2) != 0);
                r_addr = 4'($urandom_range(0, 3));
                r_len  = 2'($urandom_range(0, 3));
                r_data = $urandom;
            end
            drive(r_req, r_addr, r_len, r_data, ($urandom_range(0, 9) < 6),
                  4'($urandom_range(0, 3)));
            cyc();
        end

        // Drain and compare the array with the expected register contents.
        drive(1'b0, 4'd0, 2'd0, 32'd0, 1'b0, 4'd0);
        cyc();
        cyc();
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], shadow[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
